// File: rtl/fdiv_pkg.sv
// Shared constants and types for the single-precision divider.
// fdiv and the mantissa pipe both import this package, so both sides agree
// on the operand widths and on the pipeline latency.
package fdiv_pkg;

    // Clock cycles from an accepted operand pair to its quotient.
    localparam int FDIV_LATENCY = 10;

    // Mantissa width with the hidden bit included.
    localparam int MANT_W = 24;

    // Quotient width: one integer bit, 24 mantissa bits and one round bit.
    localparam int QUOT_W = 26;

    // Canonical quiet NaN used by fdiv on its special-case path.
    localparam logic [31:0] QUIET_NAN = 32'h7FC0_0000;

    // Stage 0 registers the operands. Every later stage except the output
    // register resolves quotient bits.
    localparam int NUM_DIV_STAGES = FDIV_LATENCY - 1;

    // Bits resolved by each divide stage, MSB first. The counts sum to QUOT_W.
    function automatic int stage_bits(input int stage);
        case (stage)
            1, 2, 3, 4, 5, 6, 7, 8: return 3;
            9:                      return 2;
            default:                return 0;
        endcase
    endfunction

    // Everything that travels down the divide pipeline with one operation.
    // rem is one bit wider than the divisor. This holds the shifted
    // remainder, which stays below 2*divisor.
    typedef struct packed {
        logic [MANT_W:0]   rem;
        logic [MANT_W-1:0] dvsr;
        logic [QUOT_W-1:0] quo;
        logic              ovf;
    } div_state_t;

endpackage

// File: rtl/fdiv_div_stage.sv
// One pipeline stage of the restoring radix-2 mantissa divider.
// The stage resolves NBITS quotient bits in combinational logic and then
// registers the updated remainder, the partial quotient and the flags.
module fdiv_div_stage
    import fdiv_pkg::*;
#(
    parameter int NBITS       = 3,
    // The first stage resolves quotient bit 25 straight from the dividend,
    // so its first step must not shift the remainder.
    parameter bit SHIFT_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  div_state_t in_st,
    output logic       out_valid,
    output div_state_t out_st
);

    div_state_t nxt_st;

    // NBITS restoring steps: shift, compare against the divisor, and subtract
    // when the remainder fits.
    always_comb begin
        // NOTE: give every always_comb output a full default before any
        // conditional update. Any path that leaves it unassigned infers a latch.
        nxt_st = in_st;
        for (int k = 0; k < NBITS; k++) begin
            if (SHIFT_FIRST || k != 0) begin
                nxt_st.rem = {nxt_st.rem[MANT_W-1:0], 1'b0};
            end
            if (nxt_st.rem >= {1'b0, nxt_st.dvsr}) begin
                nxt_st.rem = nxt_st.rem - {1'b0, nxt_st.dvsr};
                nxt_st.quo = {nxt_st.quo[QUOT_W-2:0], 1'b1};
            end else begin
                nxt_st.quo = {nxt_st.quo[QUOT_W-2:0], 1'b0};
            end
        end
    end

    // The stage register. The valid bit follows every cycle. The data
    // registers load only on a valid operation, so a bubble leaves them as
    // they are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_st    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_st <= nxt_st;
            end
        end
    end

endmodule

// File: rtl/fdiv_mantissa_pipe.sv
// Fully pipelined unsigned mantissa divider for single-precision fdiv.
// The block accepts one 24-bit dividend/divisor pair on every clock. It
// returns floor(diviend * 2^25 / divisor) as a 26-bit quotient exactly
// FDIV_LATENCY clocks later.
//
// The quotient saturates to all ones in two cases: the divisor is zero, or
// the ratio is 2 or more. A ratio of 2 or more only happens with a subnormal
// divisor. fdiv replaces both cases on its special-case path.
//
// Operand and quotient widths come from fdiv_pkg (MANT_W, QUOT_W), and so
// does the latency. The round/pack stage in fdiv depends on these values.
module fdiv_mantissa_pipe
    import fdiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              input_valid,
    input  logic [MANT_W-1:0] diviend,
    input  logic [MANT_W-1:0] divisor,
    output logic [QUOT_W-1:0] quotient,
    output logic              out_valid
);

    // ------------------------------------------------------------------
    // Stage 0: operand register
    // ------------------------------------------------------------------
    div_state_t st0;
    logic       vld0;
    logic       ovf_in;

    // Flag the operand pairs whose quotient does not fit in QUOT_W bits.
    assign ovf_in = (divisor == '0) || ({1'b0, diviend} >= {divisor, 1'b0});

    // Capture the operands. The starting remainder is the dividend itself.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written only with non-blocking
        // assignments. All flops then update together, whatever order the
        // always blocks run in.
        if (!rst_n) begin
            // NOTE: the datapath registers are cleared along with the valid
            // bits. Operands from before the reset can then never leak
            // through a stage that is holding.
            vld0 <= 1'b0;
            st0  <= '0;
        end else begin
            vld0 <= input_valid;
            if (input_valid) begin
                st0.rem  <= {1'b0, diviend};
                st0.dvsr <= divisor;
                st0.quo  <= '0;
                st0.ovf  <= ovf_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stages 1..NUM_DIV_STAGES: restoring divide, MSB first
    // ------------------------------------------------------------------
    div_state_t st_q  [1:NUM_DIV_STAGES];
    logic       vld_q [1:NUM_DIV_STAGES];

    for (genvar s = 1; s <= NUM_DIV_STAGES; s++) begin : g_stage
        div_state_t st_in;
        logic       vld_in;

        if (s == 1) begin : g_first
            assign st_in  = st0;
            assign vld_in = vld0;
        end else begin : g_next
            assign st_in  = st_q[s-1];
            assign vld_in = vld_q[s-1];
        end

        fdiv_div_stage #(
            .NBITS       (stage_bits(s)),
            .SHIFT_FIRST (s != 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_in),
            .in_st     (st_in),
            .out_valid (vld_q[s]),
            .out_st    (st_q[s])
        );
    end

    // The quotient is truncated, so the final remainder and the carried
    // divisor leave the last stage without being needed.
    logic unused_tail;
    assign unused_tail = ^{st_q[NUM_DIV_STAGES].rem, st_q[NUM_DIV_STAGES].dvsr};

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Drive the quotient, saturated on overflow. The quotient holds its last
    // value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            quotient  <= '0;
        end else begin
            out_valid <= vld_q[NUM_DIV_STAGES];
            if (vld_q[NUM_DIV_STAGES]) begin
                quotient <= st_q[NUM_DIV_STAGES].ovf ? {QUOT_W{1'b1}}
                                                     : st_q[NUM_DIV_STAGES].quo;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_mantissa_pipe.sv
// Self-checking bench for fdiv_mantissa_pipe.
// The bench pushes the expected quotient onto a queue when it drives an
// operand pair. A negedge monitor pops the queue whenever out_valid is high.
// The same monitor compares out_valid with the bench's own copy of
// input_valid, delayed by the latency.
module tb_fdiv_mantissa_pipe;
    import fdiv_pkg::*;

    localparam int LAT = FDIV_LATENCY;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              input_valid = 1'b0;
    logic [MANT_W-1:0] diviend     = '0;
    logic [MANT_W-1:0] divisor     = '0;
    logic [QUOT_W-1:0] quotient;
    logic              out_valid;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    logic [QUOT_W-1:0] sb [$];
    logic [LAT:0]      exp_v;

    typedef struct {
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        logic [QUOT_W-1:0] q;
    } vec_t;

    always #5 clk = ~clk;

    fdiv_mantissa_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_valid (input_valid),
        .diviend     (diviend),
        .divisor     (divisor),
        .quotient    (quotient),
        .out_valid   (out_valid)
    );

    // Reference quotient: floor(a * 2^25 / b), saturated when b is 0 or a >= 2b.
    function automatic logic [QUOT_W-1:0] model(input logic [MANT_W-1:0] a,
                                                input logic [MANT_W-1:0] b);
        longint unsigned la;
        longint unsigned lb;
        la = longint'(a);
        lb = longint'(b);
        if (lb == 0 || la >= 2 * lb) return '1;
        return QUOT_W'((la << 25) / lb);
    endfunction

    // Copy of input_valid, delayed so that bit LAT lines up with out_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_v <= '0;
        else        exp_v <= {exp_v[LAT-1:0], input_valid};
    end

    // Scoreboard and valid-pattern monitor.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            checks++;
            if (out_valid !== exp_v[LAT]) begin
                errors++;
                $display("FAIL valid_pattern t=%0t out_valid=%b expected=%b", $time, out_valid, exp_v[LAT]);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output t=%0t quotient=%h expected=none", $time, quotient);
                end else begin
                    logic [QUOT_W-1:0] e;
                    e = sb.pop_front();
                    if (quotient !== e) begin
                        errors++;
                        $display("FAIL quotient t=%0t got=%h expected=%h", $time, quotient, e);
                    end
                end
            end
        end
    end

    // Drive one cycle of stimulus. The caller is at posedge+1; the task returns at the next posedge+1.
    task automatic drive(input logic v, input logic [MANT_W-1:0] a,
                         input logic [MANT_W-1:0] b, input logic [QUOT_W-1:0] e);
        input_valid = v;
        diviend     = a;
        divisor     = b;
        if (v) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, MANT_W'($urandom), MANT_W'($urandom), '0);
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        input_valid = 1'b1;
        diviend     = 24'h800000;
        divisor     = 24'h800000;
        #22;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b expected=0", out_valid);
        end
        checks++;
        if (quotient !== '0) begin
            errors++;
            $display("FAIL reset_quotient got=%h expected=0", quotient);
        end
        input_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(LAT + 2);
    endtask

    task automatic test_latency;
        int                lat;
        logic [QUOT_W-1:0] q;
        lat = -1;
        q   = '0;
        drive(1'b1, 24'h800000, 24'h800000, 26'h2000000);
        for (int c = 1; c <= 20; c++) begin
            idle(1);
            @(negedge clk);
            if (out_valid === 1'b1 && lat < 0) begin
                lat = c;
                q   = quotient;
            end
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency got=%0d expected=%0d", lat, LAT);
        end
        checks++;
        if (q !== 26'h2000000) begin
            errors++;
            $display("FAIL latency_quotient got=%h expected=%h", q, 26'h2000000);
        end
    endtask

    task automatic test_directed;
        vec_t v [$];
        v.push_back('{24'hC00000, 24'h800000, 26'h3000000});
        v.push_back('{24'h800000, 24'hC00000, 26'h1555555});
        v.push_back('{24'hFFFFFF, 24'h800000, 26'h3FFFFFC});
        v.push_back('{24'h000000, 24'hABCDEF, 26'h0000000});
        v.push_back('{24'h123456, 24'h000000, 26'h3FFFFFF});
        v.push_back('{24'hFFFFFF, 24'h000001, 26'h3FFFFFF});
        v.push_back('{24'hFFFFFF, 24'hFFFFFF, 26'h2000000});
        v.push_back('{24'h800000, 24'hFFFFFF, 26'h1000001});
        v.push_back('{24'h800000, 24'h400000, 26'h3FFFFFF});
        v.push_back('{24'h7FFFFF, 24'h400000, 26'h3FFFFF8});
        v.push_back('{24'h000001, 24'h400000, 26'h0000008});
        foreach (v[i]) drive(1'b1, v[i].a, v[i].b, v[i].q);
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL directed_drain pending=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_hold;
        drive(1'b1, 24'h800000, 24'hC00000, 26'h1555555);
        for (int c = 1; c <= 25; c++) begin
            idle(1);
            @(negedge clk);
            if (c > LAT) begin
                checks++;
                if (out_valid !== 1'b0 || quotient !== 26'h1555555) begin
                    errors++;
                    $display("FAIL hold c=%0d got=%b/%h expected=0/%h", c, out_valid, quotient, 26'h1555555);
                end
            end
        end
    endtask

    task automatic test_reset_in_flight;
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = {1'b1, 23'($urandom)};
            b = {1'b1, 23'($urandom)};
            drive(1'b1, a, b, model(a, b));
        end
        #2;
        rst_n       = 1'b0;
        input_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got=%b expected=0", out_valid);
        end
        checks++;
        if (quotient !== '0) begin
            errors++;
            $display("FAIL midreset_quotient got=%h expected=0", quotient);
        end
        sb.delete();
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(LAT + 5);
        drive(1'b1, 24'hC00000, 24'h800000, 26'h3000000);
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_drain pending=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int                n;
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        n = 0;
        while (n < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                a = {1'b1, 23'($urandom)};
                b = {1'b1, 23'($urandom)};
                drive(1'b1, a, b, model(a, b));
                n++;
            end
        end
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain pending=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_hold();
        test_reset_in_flight();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
